// File: rtl/rs_relay_tail_fifo.sv
// rs_relay_tail_fifo
//
// Receiving FIFO at the tail of a register-relayed (FF pipeline) link.
// The upstream side has no per-beat backpressure.
// in_ready is a credit that travels PIPELINE_LEVEL registers to the head.
// Beats keep arriving for a full round trip after in_ready falls.
// in_ready is therefore dropped early enough that 2*PIPELINE_LEVEL+1 slots
// stay free to absorb those in-flight beats.
//
// Ports
//   clk          : single clock, all state changes on the rising edge
//   ap_rst_n     : synchronous active-low reset
//   in_din       : payload from the pipeline tail
//   in_write     : in_din valid this cycle (always accepted while not full)
//   in_ready     : registered credit back to the pipeline head
//   out_dout     : head entry, first-word-fall-through
//   out_empty_n  : head entry valid
//   out_read     : pop the head (ignored while empty)
//   overflow_err : sticky, set when a write had to be dropped
//   count        : current occupancy, 0..DEPTH

module rs_relay_tail_fifo #(
    parameter int DATA_WIDTH     = 32,
    parameter int PIPELINE_LEVEL = 8,
    parameter int DEPTH          = 32
) (
    input  logic                           clk,
    input  logic                           ap_rst_n,
    input  logic [DATA_WIDTH-1:0]          in_din,
    input  logic                           in_write,
    output logic                           in_ready,
    output logic [DATA_WIDTH-1:0]          out_dout,
    output logic                           out_empty_n,
    input  logic                           out_read,
    output logic                           overflow_err,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int CNT_W     = $clog2(DEPTH + 1);
    localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int READY_MAX = DEPTH - 2 * PIPELINE_LEVEL - 1;

    // The credit scheme only works if a full round trip of in-flight beats
    // still fits after in_ready drops.
    generate
        if (DEPTH < 2 * PIPELINE_LEVEL + 2) begin : g_depth_check
            $error("rs_relay_tail_fifo: DEPTH must be >= 2*PIPELINE_LEVEL+2");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             in_ready_q;
    logic             overflow_q;

    logic             rd_en;
    logic             wr_en;
    logic             drop;
    logic [CNT_W-1:0] count_next;
    logic [PTR_W-1:0] wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_next;

    // Accept/pop decisions and next-state values.
    // A write into a full buffer is still accepted when the head is popped
    // in the same cycle.
    // There is no same-cycle bypass: at count 0, rd_en stays low, so the
    // write is simply stored.
    // Pointers wrap explicitly at DEPTH-1 so that non-power-of-two depths
    // work correctly.
    always_comb begin
        rd_en       = 1'b0;
        wr_en       = 1'b0;
        drop        = 1'b0;
        count_next  = count_q;
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;

        rd_en = out_read && (count_q != '0);
        wr_en = in_write && ((count_q < CNT_W'(DEPTH)) || rd_en);
        drop  = in_write && !wr_en;

        count_next = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);

        if (wr_en) begin
            wr_ptr_next = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
        end
        if (rd_en) begin
            rd_ptr_next = (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
        end
    end

    // Control state.
    // in_ready is computed from the next occupancy so that the registered
    // credit already reflects the current cycle's write.
    // While reset is held it stays 0, and it rises on the first edge after
    // release.
    always_ff @(posedge clk) begin
        if (!ap_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_next;
            rd_ptr     <= rd_ptr_next;
            count_q    <= count_next;
            in_ready_q <= (count_next <= CNT_W'(READY_MAX));
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage array.
    // It has no reset; writes are gated off during reset so that a beat
    // presented in the reset cycle leaves no trace.
    always_ff @(posedge clk) begin
        if (ap_rst_n && wr_en) begin
            mem[wr_ptr] <= in_din;
        end
    end

    assign out_dout     = mem[rd_ptr];
    assign out_empty_n  = (count_q != '0);
    assign in_ready     = in_ready_q;
    assign overflow_err = overflow_q;
    assign count        = count_q;

endmodule

// File: tb/tb_rs_relay_tail_fifo.sv
// tb_rs_relay_tail_fifo
//
// Directed bench for rs_relay_tail_fifo.
// One instance uses the defaults (DEPTH=32, PIPELINE_LEVEL=8).
// A second instance uses DEPTH=20 and is driven by a random stream that is
// checked against a queue model.

module tb_rs_relay_tail_fifo;

    logic        clk;
    logic        ap_rst_n;

    // default instance
    logic [31:0] din;
    logic        wr;
    logic        rd;
    logic        in_ready;
    logic [31:0] dout;
    logic        empty_n;
    logic        ovf;
    logic [5:0]  cnt;

    // DEPTH=20 instance
    logic [31:0] din2;
    logic        wr2;
    logic        rd2;
    logic        in_ready2;
    logic [31:0] dout2;
    logic        empty_n2;
    logic        ovf2;
    logic [4:0]  cnt2;

    int vectors;
    int miscompares;

    rs_relay_tail_fifo dut (
        .clk          (clk),
        .ap_rst_n     (ap_rst_n),
        .in_din       (din),
        .in_write     (wr),
        .in_ready     (in_ready),
        .out_dout     (dout),
        .out_empty_n  (empty_n),
        .out_read     (rd),
        .overflow_err (ovf),
        .count        (cnt)
    );

    rs_relay_tail_fifo #(
        .DATA_WIDTH     (32),
        .PIPELINE_LEVEL (8),
        .DEPTH          (20)
    ) dut20 (
        .clk          (clk),
        .ap_rst_n     (ap_rst_n),
        .in_din       (din2),
        .in_write     (wr2),
        .in_ready     (in_ready2),
        .out_dout     (dout2),
        .out_empty_n  (empty_n2),
        .out_read     (rd2),
        .overflow_err (ovf2),
        .count        (cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one cycle and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        tick();
        tick();
        vectors++;
        if (cnt !== 6'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_count: got %0d expected 0", cnt);
        end
        vectors++;
        if (empty_n !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_empty_n: got %b expected 0", empty_n);
        end
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        vectors++;
        if (ovf !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_overflow: got %b expected 0", ovf);
        end
        ap_rst_n = 1'b1;
        tick();
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL release_in_ready: got %b expected 1", in_ready);
        end
        vectors++;
        if (in_ready2 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL release_in_ready_d20: got %b expected 1", in_ready2);
        end
    endtask

    task automatic test_single_write();
        din = 32'hA5A5_A5A5;
        wr  = 1'b1;
        tick();
        wr  = 1'b0;
        vectors++;
        if (empty_n !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL single_empty_n: got %b expected 1", empty_n);
        end
        vectors++;
        if (dout !== 32'hA5A5_A5A5) begin
            miscompares++;
            $display("[TB] FAIL single_dout: got %h expected a5a5a5a5", dout);
        end
        vectors++;
        if (cnt !== 6'd1) begin
            miscompares++;
            $display("[TB] FAIL single_count: got %0d expected 1", cnt);
        end
        rd = 1'b1;
        tick();
        rd = 1'b0;
        vectors++;
        if (empty_n !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_pop_empty_n: got %b expected 0", empty_n);
        end
        vectors++;
        if (cnt !== 6'd0) begin
            miscompares++;
            $display("[TB] FAIL single_pop_count: got %0d expected 0", cnt);
        end
        // popping an empty buffer must do nothing
        rd = 1'b1;
        tick();
        rd = 1'b0;
        vectors++;
        if (cnt !== 6'd0) begin
            miscompares++;
            $display("[TB] FAIL empty_read_count: got %0d expected 0", cnt);
        end
    endtask

    // fill, overflow, full write+read, then drain in order
    task automatic test_fill_overflow_drain();
        logic [31:0] exp_data [32];
        for (int i = 0; i < 32; i++) begin
            din = 32'hC000_0000 + i;
            wr  = 1'b1;
            tick();
            vectors++;
            if (cnt !== 6'(i + 1)) begin
                miscompares++;
                $display("[TB] FAIL fill_count[%0d]: got %0d expected %0d", i, cnt, i + 1);
            end
            vectors++;
            if (in_ready !== ((i + 1) <= 15)) begin
                miscompares++;
                $display("[TB] FAIL fill_in_ready[%0d]: got %b expected %b", i, in_ready, (i + 1) <= 15);
            end
        end
        wr = 1'b0;
        vectors++;
        if (ovf !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL full_no_overflow: got %b expected 0", ovf);
        end

        // one write too many
        din = 32'hDEAD_BEEF;
        wr  = 1'b1;
        tick();
        wr  = 1'b0;
        vectors++;
        if (ovf !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL overflow_set: got %b expected 1", ovf);
        end
        vectors++;
        if (cnt !== 6'd32) begin
            miscompares++;
            $display("[TB] FAIL overflow_count: got %0d expected 32", cnt);
        end
        tick();
        vectors++;
        if (ovf !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL overflow_sticky: got %b expected 1", ovf);
        end

        // full with simultaneous write and read
        vectors++;
        if (dout !== 32'hC000_0000) begin
            miscompares++;
            $display("[TB] FAIL full_head: got %h expected c0000000", dout);
        end
        din = 32'h1234_5678;
        wr  = 1'b1;
        rd  = 1'b1;
        tick();
        wr  = 1'b0;
        rd  = 1'b0;
        vectors++;
        if (cnt !== 6'd32) begin
            miscompares++;
            $display("[TB] FAIL full_rw_count: got %0d expected 32", cnt);
        end
        vectors++;
        if (dout !== 32'hC000_0001) begin
            miscompares++;
            $display("[TB] FAIL full_rw_head: got %h expected c0000001", dout);
        end

        for (int i = 0; i < 31; i++) exp_data[i] = 32'hC000_0001 + i;
        exp_data[31] = 32'h1234_5678;

        for (int k = 0; k < 32; k++) begin
            vectors++;
            if (dout !== exp_data[k]) begin
                miscompares++;
                $display("[TB] FAIL drain_data[%0d]: got %h expected %h", k, dout, exp_data[k]);
            end
            rd = 1'b1;
            tick();
            vectors++;
            if (cnt !== 6'(31 - k)) begin
                miscompares++;
                $display("[TB] FAIL drain_count[%0d]: got %0d expected %0d", k, cnt, 31 - k);
            end
            vectors++;
            if (in_ready !== ((31 - k) <= 15)) begin
                miscompares++;
                $display("[TB] FAIL drain_in_ready[%0d]: got %b expected %b", k, in_ready, (31 - k) <= 15);
            end
        end
        rd = 1'b0;
        vectors++;
        if (empty_n !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL drained_empty_n: got %b expected 0", empty_n);
        end
        vectors++;
        if (ovf !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL drained_overflow: got %b expected 1", ovf);
        end
    endtask

    task automatic test_reset_mid_op();
        for (int i = 0; i < 10; i++) begin
            din = 32'hB000_0000 + i;
            wr  = 1'b1;
            tick();
        end
        wr = 1'b0;
        vectors++;
        if (cnt !== 6'd10) begin
            miscompares++;
            $display("[TB] FAIL midrst_precount: got %0d expected 10", cnt);
        end
        ap_rst_n = 1'b0;
        din      = 32'hFFFF_FFFF;
        wr       = 1'b1;
        rd       = 1'b1;
        tick();
        wr = 1'b0;
        rd = 1'b0;
        vectors++;
        if (cnt !== 6'd0) begin
            miscompares++;
            $display("[TB] FAIL midrst_count: got %0d expected 0", cnt);
        end
        vectors++;
        if (empty_n !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midrst_empty_n: got %b expected 0", empty_n);
        end
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midrst_in_ready: got %b expected 0", in_ready);
        end
        vectors++;
        if (ovf !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midrst_overflow: got %b expected 0", ovf);
        end
        ap_rst_n = 1'b1;
        tick();
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midrst_release_in_ready: got %b expected 1", in_ready);
        end
        vectors++;
        if (cnt !== 6'd0) begin
            miscompares++;
            $display("[TB] FAIL midrst_release_count: got %0d expected 0", cnt);
        end
    endtask

    // random traffic on the DEPTH=20 instance against a queue model
    task automatic test_random_depth20();
        logic [31:0] model_q [$];
        logic        exp_ovf;
        logic        rd_eff;
        logic        wr_acc;
        int          pushes;
        exp_ovf = 1'b0;
        pushes  = 0;
        for (int c = 0; c < 100; c++) begin
            wr2  = ($urandom_range(0, 9) < 6);
            rd2  = ($urandom_range(0, 9) < 4);
            din2 = $urandom;
            if (model_q.size() != 0) begin
                vectors++;
                if (dout2 !== model_q[0]) begin
                    miscompares++;
                    $display("[TB] FAIL d20_data[%0d]: got %h expected %h", c, dout2, model_q[0]);
                end
            end
            rd_eff = rd2 && (model_q.size() != 0);
            wr_acc = wr2 && ((model_q.size() < 20) || rd_eff);
            if (wr2 && !wr_acc) exp_ovf = 1'b1;
            tick();
            if (rd_eff) void'(model_q.pop_front());
            if (wr_acc) begin
                model_q.push_back(din2);
                pushes++;
            end
            vectors++;
            if (cnt2 !== 5'(model_q.size())) begin
                miscompares++;
                $display("[TB] FAIL d20_count[%0d]: got %0d expected %0d", c, cnt2, model_q.size());
            end
            vectors++;
            if (empty_n2 !== (model_q.size() != 0)) begin
                miscompares++;
                $display("[TB] FAIL d20_empty_n[%0d]: got %b expected %b", c, empty_n2, model_q.size() != 0);
            end
            vectors++;
            if (in_ready2 !== (model_q.size() <= 3)) begin
                miscompares++;
                $display("[TB] FAIL d20_in_ready[%0d]: got %b expected %b", c, in_ready2, model_q.size() <= 3);
            end
            vectors++;
            if (ovf2 !== exp_ovf) begin
                miscompares++;
                $display("[TB] FAIL d20_overflow[%0d]: got %b expected %b", c, ovf2, exp_ovf);
            end
        end
        wr2 = 1'b0;
        rd2 = 1'b0;
        // drain what is left so that every stored word passes the head
        for (int k = 0; k < 20 && model_q.size() != 0; k++) begin
            vectors++;
            if (dout2 !== model_q[0]) begin
                miscompares++;
                $display("[TB] FAIL d20_drain[%0d]: got %h expected %h", k, dout2, model_q[0]);
            end
            rd2 = 1'b1;
            tick();
            void'(model_q.pop_front());
        end
        rd2 = 1'b0;
        vectors++;
        if (empty_n2 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL d20_drained_empty_n: got %b expected 0", empty_n2);
        end
        $display("[TB] depth-20 stream pushed %0d words", pushes);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        ap_rst_n    = 1'b0;
        din         = '0;
        wr          = 1'b0;
        rd          = 1'b0;
        din2        = '0;
        wr2         = 1'b0;
        rd2         = 1'b0;

        test_reset();
        test_single_write();
        test_fill_overflow_drain();
        test_reset_mid_op();
        test_random_depth20();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
